// File: rtl/ram_req_ctrl_if.sv
// Request/response handshake bundle between a requester and ram_req_ctrl.
interface ram_req_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // Requester side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Valid/ready front-end for a single-port synchronous RAM with 1-cycle read
// latency. Writes complete at acceptance; reads are buffered in a small
// response FIFO. Out-of-range reads return zero data with an error flag.
module ram_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_req_ctrl_if.slave         bus,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  localparam int PTR_W = (RSP_DEPTH <= 1) ? 1 : $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
  logic                  r_fifo_err  [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd_pend;
  logic                  r_rd_pend_err;

  logic                  w_oor;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_req_ready;
  logic                  w_acc;
  logic                  w_acc_rd;
  logic [31:0]           w_occ;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  // Acceptance, back-pressure and address range decode.
  always_comb begin
    w_oor  = 32'(bus.req_addr) >= 32'(DEPTH);
    w_pop  = (r_count != '0) && bus.rsp_ready;
    w_push = r_rd_pend;
    // Occupancy once the in-flight read lands, crediting a pop on this edge.
    w_occ  = 32'(r_count) + 32'(r_rd_pend) - 32'(w_pop);
    w_req_ready = bus.req_we ? 1'b1 : (w_occ < 32'(RSP_DEPTH));
    w_acc    = bus.req_valid && w_req_ready;
    w_acc_rd = w_acc && !bus.req_we;
    w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
  end

  // RAM port is driven straight from the request; OOR writes are dropped.
  always_comb begin
    ram_addr    = bus.req_addr;
    ram_data_in = bus.req_wdata;
    ram_w_en    = w_acc && bus.req_we && !w_oor;
  end

  // Response side shows the FIFO head.
  always_comb begin
    bus.req_ready = w_req_ready;
    bus.rsp_valid = (r_count != '0);
    bus.rsp_rdata = r_fifo_data[r_rd_ptr];
    bus.rsp_err   = r_fifo_err[r_rd_ptr];
  end

  // Track the read whose RAM data arrives on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend     <= 1'b0;
      r_rd_pend_err <= 1'b0;
    end else begin
      r_rd_pend <= w_acc_rd;
      if (w_acc_rd) r_rd_pend_err <= w_oor;
    end
  end

  // Circular response FIFO; push is the landing read, pop is the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= r_rd_pend_err ? '0 : ram_data_out;
        r_fifo_err[r_wr_ptr]  <= r_rd_pend_err;
        r_wr_ptr              <= w_wr_ptr_nxt;
      end
      if (w_pop) r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a scoreboard: reads push expected
// responses at acceptance, a negedge monitor pops and compares on each pop.
module tb_ram_req_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int RSPD  = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_w_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] mem [16];

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t exp_q[$];
  int   w;

  ram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_req_ctrl #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .RSP_DEPTH(RSPD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ram_w_en(ram_w_en),
    .ram_addr(ram_addr),
    .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with 1-cycle read latency; never reset.
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA5A50000 + 32'(i);
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pop is compared against the scoreboard head.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got data 0x%0h err %0b expected no response",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.d));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    check("wr_ready", 64'(bus.req_ready), 64'd1);
    check("ram_w_en", 64'(ram_w_en), (32'(a) < DEPTH) ? 64'd1 : 64'd0);
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  // Presents a read until accepted (bounded); leaves req_valid high.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic e, output int waits);
    rsp_t r;
    bit ok;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    ok    = 1'b0;
    waits = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      else waits++;
    end
    if (ok) begin
      @(posedge clk);
      r.d = d;
      r.e = e;
      exp_q.push_back(r);
      #1;
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL rd_accept_timeout: addr %0d not accepted, required acceptance", a);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_ram_w_en", 64'(ram_w_en), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Write then read with 2-edge latency.
    do_write(4'd3, 32'hDEADBEEF);
    bus.rsp_ready = 1'b1;
    do_read(4'd3, 32'hDEADBEEF, 1'b0, w);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_e0", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_valid_e1", 64'(bus.rsp_valid), 64'd1);
    drain();

    // Back-to-back reads at full rate.
    do_write(4'd7, 32'h12345678);
    do_write(4'd3, 32'hCAFEBABE);
    do_read(4'd3, 32'hCAFEBABE, 1'b0, w);
    check("b2b_wait0", 64'(w), 64'd0);
    do_read(4'd7, 32'h12345678, 1'b0, w);
    check("b2b_wait1", 64'(w), 64'd0);
    do_read(4'd3, 32'hCAFEBABE, 1'b0, w);
    check("b2b_wait2", 64'(w), 64'd0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid_a", 64'(bus.rsp_valid), 64'd1);
    @(negedge clk);
    check("b2b_valid_b", 64'(bus.rsp_valid), 64'd1);
    @(negedge clk);
    check("b2b_valid_end", 64'(bus.rsp_valid), 64'd0);
    drain();

    // Back-pressure: reads stall, writes do not.
    bus.rsp_ready = 1'b0;
    do_read(4'd3, 32'hCAFEBABE, 1'b0, w);
    do_read(4'd7, 32'h12345678, 1'b0, w);
    bus.req_addr = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_stall", 64'(bus.req_ready), 64'd0);
    end
    step();
    do_write(4'd5, 32'h55AA55AA);
    bus.rsp_ready = 1'b1;
    do_read(4'd5, 32'h55AA55AA, 1'b0, w);
    check("rd_resume_wait", 64'(w), 64'd0);
    bus.req_valid = 1'b0;
    drain();

    // Out-of-range handling (DEPTH=12).
    do_write(4'd13, 32'hFFFFFFFF);
    do_write(4'd11, 32'h0B0B0B0B);
    do_read(4'd13, 32'h0, 1'b1, w);
    do_read(4'd11, 32'h0B0B0B0B, 1'b0, w);
    bus.req_valid = 1'b0;
    drain();

    // Head held stable under back-pressure; simultaneous pop and read.
    bus.rsp_ready = 1'b0;
    do_read(4'd3, 32'hCAFEBABE, 1'b0, w);
    do_read(4'd7, 32'h12345678, 1'b0, w);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rdata", 64'(bus.rsp_rdata), 64'hCAFEBABE);
      check("hold_err", 64'(bus.rsp_err), 64'd0);
    end
    step();
    bus.rsp_ready = 1'b1;
    do_read(4'd11, 32'h0B0B0B0B, 1'b0, w);
    check("popacc_wait", 64'(w), 64'd0);
    bus.rsp_ready = 1'b0;
    bus.req_addr  = 4'd3;
    @(negedge clk);
    check("popacc_full_a", 64'(bus.req_ready), 64'd0);
    check("popacc_head", 64'(bus.rsp_rdata), 64'h12345678);
    step();
    @(negedge clk);
    check("popacc_full_b", 64'(bus.req_ready), 64'd0);
    step();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset mid-operation with one buffered response and one pending read.
    bus.rsp_ready = 1'b0;
    do_read(4'd3, 32'hCAFEBABE, 1'b0, w);
    do_read(4'd7, 32'h12345678, 1'b0, w);
    bus.req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_rdata", 64'(bus.rsp_rdata), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_stale", 64'(bus.rsp_valid), 64'd0);
    end
    step();
    do_read(4'd3, 32'hCAFEBABE, 1'b0, w);
    bus.req_valid = 1'b0;
    drain();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
